// File: rtl/datapath_ctrl.sv
`default_nettype none
// ============================================================================
// datapath_ctrl : instruction-sequencing FSM driving the datapath controls
// Rev 1.0
// ============================================================================
module datapath_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        illegal,
  output logic [15:0] datapath_in,
  output logic        vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  localparam logic [2:0] C_WAIT      = 3'd0;
  localparam logic [2:0] C_DECODE    = 3'd1;
  localparam logic [2:0] C_WRITE_IMM = 3'd2;
  localparam logic [2:0] C_GET_A     = 3'd3;
  localparam logic [2:0] C_GET_B     = 3'd4;
  localparam logic [2:0] C_ALU       = 3'd5;
  localparam logic [2:0] C_CMP_S     = 3'd6;
  localparam logic [2:0] C_WRITE_REG = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic        w_is_mov_imm;
  logic        w_is_mov_reg;
  logic        w_is_alu;
  logic        w_is_cmp;
  logic        w_is_mvn;

  assign w_opcode     = ir_q[15:13];
  assign w_op         = ir_q[12:11];
  assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_is_alu     = (w_opcode == 3'b101);
  assign w_is_cmp     = w_is_alu && (w_op == 2'b01);
  assign w_is_mvn     = w_is_alu && (w_op == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= C_WAIT;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      C_WAIT: begin
        if (s) begin
          ir_d      = instr;
          illegal_d = 1'b0;
          state_d   = C_DECODE;
        end
      end
      C_DECODE: begin
        if (w_is_mov_imm)
          state_d = C_WRITE_IMM;
        else if (w_is_mov_reg || w_is_mvn)
          state_d = C_GET_B;
        else if (w_is_alu)
          state_d = C_GET_A;
        else begin
          illegal_d = 1'b1;
          state_d   = C_WAIT;
        end
      end
      C_WRITE_IMM: state_d = C_WAIT;
      C_GET_A:     state_d = C_GET_B;
      C_GET_B:     state_d = w_is_cmp ? C_CMP_S : C_ALU;
      C_ALU:       state_d = C_WRITE_REG;
      C_CMP_S:     state_d = C_WAIT;
      C_WRITE_REG: state_d = C_WAIT;
      default:     state_d = C_WAIT;
    endcase
  end

  assign illegal     = illegal_q;
  assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

  // Moore outputs: everything defaults low, each state raises only its own controls
  always_comb begin
    w        = 1'b0;
    vsel     = 1'b0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      C_WAIT: w = 1'b1;
      C_WRITE_IMM: begin
        vsel     = 1'b1;
        writenum = ir_q[10:8];
        write    = 1'b1;
      end
      C_GET_A: begin
        readnum = ir_q[10:8];
        loada   = 1'b1;
      end
      C_GET_B: begin
        readnum = ir_q[2:0];
        loadb   = 1'b1;
      end
      C_ALU: begin
        shift = ir_q[4:3];
        loadc = 1'b1;
        if (w_is_mov_reg)
          asel = 1'b1;
        else
          ALUop = w_op;
      end
      C_CMP_S: begin
        shift = ir_q[4:3];
        ALUop = 2'b01;
        loads = 1'b1;
      end
      C_WRITE_REG: begin
        writenum = ir_q[7:5];
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl.sv
`default_nettype none
// ============================================================================
// tb_datapath_ctrl : scoreboard bench with a behavioural datapath behind the FSM
// Rev 1.0
// ============================================================================
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        w, illegal, vsel, write, loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] datapath_in;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;

  datapath_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
    .w(w), .illegal(illegal), .datapath_in(datapath_in),
    .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .writenum(writenum), .readnum(readnum), .shift(shift), .ALUop(ALUop)
  );

  always #5 clk = ~clk;

  // {w,vsel,write,loada,loadb,loadc,loads,asel,bsel,writenum,readnum,shift,ALUop}
  logic [18:0] dut_vec;
  assign dut_vec = {w, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                    writenum, readnum, shift, ALUop};

  // Behavioural datapath: register file, A/B/C, status Z
  logic [15:0] regs [8];
  logic [15:0] ra, rb, rc, b_sh, ain, bin, alu_out;
  logic        rz = 1'b0;
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [15:0] pl_val = 16'h0000;

  always_comb begin
    case (shift)
      2'b01:   b_sh = {rb[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, rb[15:1]};
      2'b11:   b_sh = {rb[15], rb[15:1]};
      default: b_sh = rb;
    endcase
    ain = asel ? 16'h0000 : ra;
    bin = bsel ? datapath_in : b_sh;
    case (ALUop)
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      2'b11:   alu_out = ~bin;
      default: alu_out = ain + bin;
    endcase
  end

  always @(posedge clk) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    if (write) regs[writenum] <= vsel ? datapath_in : rc;
    if (loada) ra <= regs[readnum];
    if (loadb) rb <= regs[readnum];
    if (loadc) rc <= alu_out;
    if (loads) rz <= (alu_out == 16'h0000);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_q [$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic wv, input logic vs, input logic wr,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as,
                                     input logic [2:0] wn, input logic [2:0] rn,
                                     input logic [1:0] sh, input logic [1:0] op);
    return {wv, vs, wr, la, lb, lc, ls, as, 1'b0, wn, rn, sh, op};
  endfunction

  // Expected control trace for one instruction, DECODE through the return to WAIT
  task automatic push_exp(input logic [15:0] ins);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
    exp_q.push_back(19'd0);
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(mk(0,1,1,0,0,0,0,0, rn,3'd0,2'b00,2'b00));
    end else if (opc == 3'b110 && op == 2'b00) begin
      exp_q.push_back(mk(0,0,0,0,1,0,0,0, 3'd0,rm,2'b00,2'b00));
      exp_q.push_back(mk(0,0,0,0,0,1,0,1, 3'd0,3'd0,sh,2'b00));
      exp_q.push_back(mk(0,0,1,0,0,0,0,0, rd,3'd0,2'b00,2'b00));
    end else if (opc == 3'b101) begin
      if (op != 2'b11)
        exp_q.push_back(mk(0,0,0,1,0,0,0,0, 3'd0,rn,2'b00,2'b00));
      exp_q.push_back(mk(0,0,0,0,1,0,0,0, 3'd0,rm,2'b00,2'b00));
      if (op == 2'b01) begin
        exp_q.push_back(mk(0,0,0,0,0,0,1,0, 3'd0,3'd0,sh,2'b01));
      end else begin
        exp_q.push_back(mk(0,0,0,0,0,1,0,0, 3'd0,3'd0,sh,op));
        exp_q.push_back(mk(0,0,1,0,0,0,0,0, rd,3'd0,2'b00,2'b00));
      end
    end
    exp_q.push_back(mk(1,0,0,0,0,0,0,0, 3'd0,3'd0,2'b00,2'b00));
  endtask

  // Pops and compares one expected vector per cycle; stop_at<0 drains fully
  task automatic drain(input logic [15:0] ins, input bit tog, input int stop_at);
    logic [18:0] ev;
    int k = 0;
    while (exp_q.size() > 0 && (stop_at < 0 || k < stop_at)) begin
      @(negedge clk);
      ev = exp_q.pop_front();
      chk_eq($sformatf("%h.cyc%0d", ins, k), {13'd0, dut_vec}, {13'd0, ev});
      k++;
      s = (tog && exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    s = 1'b0;
  endtask

  task automatic run(input logic [15:0] ins, input bit tog);
    push_exp(ins);
    instr = ins;
    s = 1'b1;
    drain(ins, tog, -1);
  endtask

  task automatic preload(input logic [2:0] idx, input logic [15:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_eq("reset_vec", {13'd0, dut_vec}, {13'd0, mk(1,0,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00)});
    chk_eq("reset_dpin", {16'd0, datapath_in}, 32'd0);
    chk_eq("reset_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("post_reset_w", {31'd0, w}, 32'd1);

    // MOV R2,#-54
    push_exp(16'hD2CA);
    instr = 16'hD2CA; s = 1'b1;
    drain(16'hD2CA, 0, 2);
    chk_eq("movimm_dpin", {16'd0, datapath_in}, 32'h0000FFCA);
    drain(16'hD2CA, 0, -1);
    chk_eq("movimm_R2", {16'd0, regs[2]}, 32'h0000FFCA);

    // ADD R1,R2,R4 LSL
    preload(3'd2, 16'd202);
    preload(3'd4, 16'd51);
    run(16'hA22C, 0);
    chk_eq("add_R1", {16'd0, regs[1]}, 32'd304);

    // CMP R5,R7
    preload(3'd5, 16'd6);
    preload(3'd7, 16'd6);
    run(16'hAD07, 0);
    chk_eq("cmp_Z", {31'd0, rz}, 32'd1);
    chk_eq("cmp_C_kept", {16'd0, rc}, 32'd304);

    // MVN R3,R7 then MOV R0,R3 ASR, back-to-back
    run(16'hB867, 0);
    run(16'hC01B, 0);
    chk_eq("mvn_R3", {16'd0, regs[3]}, 32'h0000FFF9);
    chk_eq("movreg_R0", {16'd0, regs[0]}, 32'h0000FFFC);

    // Illegal opcodes, then a legal start clears the flag
    run(16'hE000, 0);
    chk_eq("illegal_set", {31'd0, illegal}, 32'd1);
    run(16'hC800, 0);
    chk_eq("illegal_op01", {31'd0, illegal}, 32'd1);
    run(16'hD105, 0);
    chk_eq("illegal_clr", {31'd0, illegal}, 32'd0);
    chk_eq("movimm_R1", {16'd0, regs[1]}, 32'd5);

    // Reset during WRITE_REG of ADD R6,R2,R4
    preload(3'd6, 16'h1234);
    push_exp(16'hA2C4);
    instr = 16'hA2C4; s = 1'b1;
    drain(16'hA2C4, 0, 4);
    @(negedge clk);
    chk_eq("pre_rst_write", {31'd0, write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_write_drop", {31'd0, write}, 32'd0);
    chk_eq("rst_w", {31'd0, w}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    chk_eq("rst_R6_kept", {16'd0, regs[6]}, 32'h00001234);

    // Release with s already high: MOV R6,#5 accepted on first clean edge
    push_exp(16'hD605);
    instr = 16'hD605; s = 1'b1;
    #1 rst_n = 1'b1;
    drain(16'hD605, 0, -1);
    chk_eq("rel_R6", {16'd0, regs[6]}, 32'd5);

    // ADD R7,R2,R4 LSR with s toggling mid-instruction
    run(16'hA2F4, 1);
    chk_eq("tog_R7", {16'd0, regs[7]}, 32'd227);
    repeat (2) @(negedge clk);
    chk_eq("idle_w", {31'd0, w}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath_ctrl.md
# datapath_ctrl

Instruction-sequencing FSM that sits directly upstream of `datapath` and drives all of its control inputs. It accepts one 16-bit instruction per start pulse, decodes it, steps the datapath through register read, ALU, status and write-back cycles, and signals completion. The FSM handles no branches and no memory; those belong to later stages.

## Interface
- No parameters (widths fixed by `datapath`: 16-bit data, 8 registers).
- `clk` in 1: rising-edge clock, shared with `datapath`.
- `rst_n` in 1: asynchronous, active-low reset.
- `s` in 1: start; sampled only in WAIT.
- `instr` in 16: instruction, captured into internal `ir` when the start is accepted.
- `w` out 1: idle/ready; 1 only in WAIT.
- `illegal` out 1: set on an undecodable instruction; held until the next accepted start.
- `datapath_in` out 16: sign-extended `ir[7:0]` (sximm8), driven in every state.
- `vsel`, `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel` out 1 each: datapath controls.
- `writenum`, `readnum` out 3 each; `shift`, `ALUop` out 2 each.

## Operation
- Fields of `ir`:
  - opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0].
- Decoded instructions:
  - opcode 110, op 10: MOV Rn,#imm8.
  - opcode 110, op 00: MOV Rd,Rm{sh}.
  - opcode 101, op 00/01/10/11: ADD, CMP, AND, MVN.
  - Any other opcode/op combination is illegal.
- Datapath semantics:
  - vsel=1 selects `datapath_in`; vsel=0 selects C.
  - asel=0 selects A; asel=1 selects zero.
  - bsel=0 selects shifter output.
  - ALUop 00 add, 01 sub, 10 and, 11 not-B.
- Outputs are Moore, decoded from state and `ir`. Default in every state: all loads/write/vsel/asel/bsel=0, shift=00, ALUop=00, readnum=writenum=0.
- States and what each drives:
  - WAIT: w=1. If s=1, capture `ir`, clear `illegal`, go to DECODE.
  - DECODE: no datapath activity. Route by instruction:
    - MOV imm goes to WRITE_IMM.
    - ADD/CMP/AND go to GET_A.
    - MOV reg/MVN go to GET_B.
    - Illegal sets `illegal` and returns to WAIT.
  - WRITE_IMM: vsel=1, writenum=Rn, write=1. Next state is WAIT.
  - GET_A: readnum=Rn, loada=1. Next state is GET_B.
  - GET_B: readnum=Rm, loadb=1. Next state is CMP_S for CMP, otherwise ALU.
  - ALU: shift=sh, bsel=0, loadc=1, ALUop=op for 101-class instructions.
    - For MOV reg: asel=1, ALUop=00.
    - Next state is WRITE_REG.
  - CMP_S: shift=sh, ALUop=01, loads=1, loadc=0. Next state is WAIT.
  - WRITE_REG: vsel=0, writenum=Rd, write=1. Next state is WAIT.
- `s` outside WAIT is ignored; an instruction always completes once accepted.
- CMP never writes a register or C.

## Timing
- Edge E0 accepts the start. Completion is measured as the edge that returns the FSM to WAIT (w=1 after it):
  - MOV imm: E2.
  - MOV reg, MVN: E4.
  - CMP: E4.
  - ADD, AND: E5.
  - Illegal: E1.
- The register-file write happens on the same edge that returns the FSM to WAIT.
- Back-to-back: if s=1 in the first WAIT cycle, the next instruction is accepted on that edge, so the minimum gap is one WAIT cycle.
- Reset values: state WAIT, `ir`=0, `illegal`=0, w=1, `datapath_in`=0, all other outputs 0.
- Reset mid-instruction: control outputs drop to defaults immediately (asynchronously); no partial write completes. After release the FSM is in WAIT.
- Reset released while s=1: the start is accepted on the first clean edge.

## Test plan
- After reset, check w=1, all controls 0, `illegal`=0. Apply MOV R2,#-54 (instr 16'hD2CA) with s pulsed.
  - Required: WRITE_IMM drives datapath_in=16'hFFCA, writenum=2, write=1.
  - Required: w=1 after E2.
- Preload R2=202 and R4=51, then run ADD R1,R2,R4 with LSL (sh=01).
  - Required: states GET_A/GET_B/ALU/WRITE_REG with readnum 2 then 4.
  - Required: C=304 written to R1 at E5.
- Preload R5=6 and R7=6, then run CMP R5,R7.
  - Required: loads=1 in CMP_S, Z=1, write never asserted.
  - Required: w=1 after E4.
- Run MVN R3,R7 then MOV R0,R3 with ASR (sh=11), back-to-back with one WAIT cycle between.
  - Required: R3=16'hFFF9 (~6).
  - Required: R0=16'hFFFC.
  - Required: asel=1 in the MOV ALU state.
- Apply instr opcode 111, s=1.
  - Required: `illegal`=1 after E1, no write/load.
  - Required: a following legal start clears `illegal`.
- Assert rst_n=0 during WRITE_REG of an ADD.
  - Required: write drops immediately, target register unchanged, FSM in WAIT with w=1.
  - Required: toggling s during GET_A of a later instruction has no effect.
